// File: rtl/m_seq_checker_pkg.sv
// Shared PRBS7 polynomial and checker FSM encodings.
// m_seq_gen imports the same polynomial constants.
package m_seq_checker_pkg;

  localparam int unsigned         PRBS_LEN  = 7;
  localparam logic [PRBS_LEN-1:0] PRBS_TAPS = 7'b1100000;

  localparam logic [1:0] ST_FILL   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

endpackage

// File: rtl/m_seq_checker_if.sv
// Per-bit receive stream from the demapper.
interface m_seq_checker_if;
  logic bit_in;
  logic bit_valid;

  modport master (output bit_in, output bit_valid);
  modport slave  (input  bit_in, input  bit_valid);
endinterface

// File: rtl/m_seq_checker_prbs_lfsr_step.sv
// One Fibonacci LFSR step. x_sel=1 free-runs on the prediction; x_sel=0 shifts in ext_bit.
module prbs_lfsr_step
  import m_seq_checker_pkg::*;
#(
  parameter int unsigned    LEN  = PRBS_LEN,
  parameter logic [LEN-1:0] TAPS = PRBS_TAPS
) (
  input  logic [LEN-1:0] state,
  input  logic           x_sel,
  input  logic           ext_bit,
  output logic [LEN-1:0] next_state,
  output logic           pred
);

  always_comb begin
    pred       = ^(state & TAPS);
    next_state = {state[LEN-2:0], (x_sel ? pred : ext_bit)};
  end

endmodule

// File: rtl/m_seq_checker.sv
// Self-synchronising PRBS checker: fills and locks a local LFSR on the received
// stream, then free-runs it and counts bit errors with loss-of-lock supervision.
module m_seq_checker
  import m_seq_checker_pkg::*;
#(
  parameter int unsigned         LFSR_LEN = PRBS_LEN,
  parameter logic [LFSR_LEN-1:0] TAPS     = PRBS_TAPS,
  parameter int unsigned         LOCK_CNT = 16,
  parameter int unsigned         WIN      = 64,
  parameter int unsigned         LOSS_ERR = 8,
  parameter int unsigned         CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  m_seq_checker_if.slave       rx,
  input  logic                 clear_cnt,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [CNT_W-1:0]     bit_cnt,
  output logic [CNT_W-1:0]     err_cnt
);

  localparam int unsigned FILL_W  = $clog2(LFSR_LEN + 1);
  localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned WIN_W   = $clog2(WIN + 1);
  localparam int unsigned WERR_W  = $clog2(LOSS_ERR + 1);

  logic [1:0]          state_q;
  logic [LFSR_LEN-1:0] lfsr_q;
  logic [LFSR_LEN-1:0] lfsr_next;
  logic                pred;
  logic                mismatch;
  logic [FILL_W-1:0]   fill_cnt_q;
  logic [MATCH_W-1:0]  match_cnt_q;
  logic [WIN_W-1:0]    win_cnt_q;
  logic [WERR_W-1:0]   win_err_q;
  logic [WERR_W-1:0]   win_err_inc;

  prbs_lfsr_step #(
    .LEN  (LFSR_LEN),
    .TAPS (TAPS)
  ) u_step (
    .state      (lfsr_q),
    .x_sel      (state_q == ST_LOCKED),
    .ext_bit    (rx.bit_in),
    .next_state (lfsr_next),
    .pred       (pred)
  );

  // Window error count including the current bit, saturating at LOSS_ERR.
  always_comb begin
    mismatch    = rx.bit_in ^ pred;
    win_err_inc = win_err_q;
    if (mismatch && (win_err_q != WERR_W'(LOSS_ERR)))
      win_err_inc = win_err_q + WERR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FILL;
      lfsr_q      <= '0;
      fill_cnt_q  <= '0;
      match_cnt_q <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
      bit_cnt     <= '0;
      err_cnt     <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (rx.bit_valid) begin
        lfsr_q <= lfsr_next;
        case (state_q)
          ST_FILL: begin
            if (fill_cnt_q == FILL_W'(LFSR_LEN - 1)) begin
              fill_cnt_q  <= '0;
              match_cnt_q <= '0;
              state_q     <= ST_SEARCH;
            end else begin
              fill_cnt_q <= fill_cnt_q + FILL_W'(1);
            end
          end
          ST_SEARCH: begin
            // An all-zero state predicts zeros forever, so it never counts as a match.
            if (!mismatch && (lfsr_q != '0)) begin
              if (match_cnt_q == MATCH_W'(LOCK_CNT - 1)) begin
                state_q   <= ST_LOCKED;
                locked    <= 1'b1;
                win_cnt_q <= '0;
                win_err_q <= '0;
              end else begin
                match_cnt_q <= match_cnt_q + MATCH_W'(1);
              end
            end else begin
              match_cnt_q <= '0;
            end
          end
          ST_LOCKED: begin
            if (bit_cnt != '1) bit_cnt <= bit_cnt + CNT_W'(1);
            if (mismatch) begin
              err_pulse <= 1'b1;
              if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
            end
            if (win_cnt_q == WIN_W'(WIN - 1)) begin
              if (win_err_inc >= WERR_W'(LOSS_ERR)) begin
                state_q    <= ST_FILL;
                locked     <= 1'b0;
                fill_cnt_q <= '0;
              end
              win_cnt_q <= '0;
              win_err_q <= '0;
            end else begin
              win_cnt_q <= win_cnt_q + WIN_W'(1);
              win_err_q <= win_err_inc;
            end
          end
          default: state_q <= ST_FILL;
        endcase
      end
      if (clear_cnt) begin
        bit_cnt <= '0;
        err_cnt <= '0;
      end
    end
  end

endmodule
